// File: rtl/protected_hamming_encoder_pkg.sv
// Shared constants and helpers for the password-gated Hamming(7,4) encoder.
// Holds the default security code, the match-count width and the encode function.
package phe_pkg;

    localparam int          PHE_CODE_LEN = 4;
    localparam logic [3:0]  PHE_CODE     = 4'b1101;

    function automatic int phe_match_w(input int code_len);
        return $clog2(code_len + 1);
    endfunction

    // Codeword bit 0 is position 1; parity bits sit at positions 1, 2 and 4.
    function automatic logic [6:0] hamming74(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/protected_hamming_encoder_if.sv
// Data-entry / codeword bundle between a user-side driver and the protected encoder.
// The master drives the code bit and nibble; the slave (encoder) returns strobe and codeword.
interface phe_if;
    logic       x;
    logic [3:0] data_in;
    logic       z;
    logic [3:0] data_out;
    logic [6:0] hamming_out;
    logic       valid;

    modport master (output x, data_in, input  z, data_out, hamming_out, valid);
    modport slave  (input  x, data_in, output z, data_out, hamming_out, valid);
endinterface

// File: rtl/protected_hamming_encoder_code_fsm.sv
// Overlapping serial security-code detector; z is high while the full code is matched.
// With UNLOCK_STICKY_EN defined the detector latches in the full-match state until reset.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   S0           | no prefix of CODE is a suffix of the received bits
//   Sk (0<k<N)   | longest received suffix equals the first k bits of CODE
//   SN           | full code matched; z = 1
module phe_code_fsm
    import phe_pkg::*;
#(
    parameter int                  CODE_LEN = PHE_CODE_LEN,
    parameter logic [CODE_LEN-1:0] CODE     = CODE_LEN'(PHE_CODE)
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    localparam int           W    = phe_match_w(CODE_LEN);
    localparam int           CW   = CODE_LEN + 1;
    localparam logic [W-1:0] FULL = W'(CODE_LEN);

    logic [W-1:0] state, state_nx;

    // Longest prefix of CODE that is a suffix of (first k code bits followed by xb).
    function automatic logic [W-1:0] next_match(input logic [W-1:0] k, input logic xb);
        logic [CW-1:0] code_ext, hist, mask, pre, one_v;
        logic [W-1:0]  best;
        code_ext = {1'b0, CODE};
        one_v    = CW'(1);
        hist     = ((code_ext >> (CODE_LEN - int'(k))) << 1) | CW'(xb);
        best     = '0;
        for (int j = 1; j <= CODE_LEN; j++) begin
            mask = (one_v << j) - one_v;
            pre  = code_ext >> (CODE_LEN - j);
            if ((j <= int'(k) + 1) && ((hist & mask) == pre))
                best = W'(j);
        end
        return best;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= '0;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        z        = 1'b0;
`ifdef UNLOCK_STICKY_EN
        if (state != FULL)
            state_nx = next_match(state, x);
`else
        state_nx = next_match(state, x);
`endif
        if (state == FULL)
            z = 1'b1;
    end

endmodule

// File: rtl/protected_hamming_encoder_hamming74.sv
// Combinational Hamming(7,4) encoder for the registered data nibble.
module phe_hamming74
    import phe_pkg::*;
(
    input  logic [3:0] data,
    output logic [6:0] code
);

    assign code = hamming74(data);

endmodule

// File: rtl/protected_hamming_encoder.sv
// Password-gated Hamming(7,4) encoder: a matched serial code loads the data nibble.
// Optional UNLOCK_STICKY_EN keeps the unlock asserted after the first match.
module protected_hamming_encoder
    import phe_pkg::*;
#(
    parameter int                  CODE_LEN = PHE_CODE_LEN,
    parameter logic [CODE_LEN-1:0] CODE     = CODE_LEN'(PHE_CODE)
) (
    input logic clk,
    input logic rst,
    phe_if.slave bus
);

    logic       z;
    logic [3:0] data_q;
    logic       valid_q;

    phe_code_fsm #(
        .CODE_LEN (CODE_LEN),
        .CODE     (CODE)
    ) u_fsm (
        .clk (clk),
        .rst (rst),
        .x   (bus.x),
        .z   (z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (z) begin
            data_q  <= bus.data_in;
            valid_q <= 1'b1;
        end
    end

    phe_hamming74 u_enc (
        .data (data_q),
        .code (bus.hamming_out)
    );

    assign bus.z        = z;
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_protected_hamming_encoder.sv
// Self-checking bench for protected_hamming_encoder against a bit-history reference model.
module tb_protected_hamming_encoder;

    localparam int         CL   = 4;
    localparam logic [3:0] CODE = 4'b1101;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    phe_if bus ();

    protected_hamming_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: history of received bits, count since reset, unlock/data/valid.
    int         m_hist, m_cnt;
    logic       m_z, m_valid;
    logic [3:0] m_data;

    function automatic logic [6:0] ref_ham(input logic [3:0] d);
        logic [7:0] cw;
        logic       p;
        int         di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= 7; pos++)
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di++;
            end
        for (int i = 0; i < 3; i++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos & (1 << i)) != 0) && (pos != (1 << i)))
                    p = p ^ cw[pos];
            cw[1 << i] = p;
        end
        return cw[7:1];
    endfunction

    task automatic model_reset();
        m_hist  = 0;
        m_cnt   = 0;
        m_z     = 1'b0;
        m_valid = 1'b0;
        m_data  = 4'h0;
    endtask

    task automatic step(input logic xb, input logic [3:0] d);
        logic hit;
        @(negedge clk);
        bus.x       = xb;
        bus.data_in = d;
        @(posedge clk);
        if (m_z) begin
            m_data  = d;
            m_valid = 1'b1;
        end
        m_hist = ((m_hist << 1) | int'(xb)) & ((1 << CL) - 1);
        m_cnt++;
        hit = (m_cnt >= CL) && (m_hist == int'(CODE));
`ifdef UNLOCK_STICKY_EN
        m_z = m_z | hit;
`else
        m_z = hit;
`endif
        #1;
    endtask

    function automatic logic [12:0] expected_bus();
        return {m_z, m_valid, m_data, ref_ham(m_data)};
    endfunction

    task automatic test_reset();
        rst         = 1'b0;
        bus.x       = 1'b0;
        bus.data_in = 4'h0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.z, bus.valid, bus.data_out, bus.hamming_out} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b want 0", {bus.z, bus.valid, bus.data_out, bus.hamming_out});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unlock_load();
        logic [3:0] xs;
        xs = CODE;
        for (int i = CL - 1; i >= 0; i--) begin
            step(xs[i], 4'b1011);
            n_checks++;
            if ({bus.z, bus.valid, bus.data_out, bus.hamming_out} !== expected_bus()) begin
                n_fail++;
                $display("FAIL unlock_seq[%0d]: got %b want %b", i, {bus.z, bus.valid, bus.data_out, bus.hamming_out}, expected_bus());
            end
        end
        n_checks++;
        if (bus.z !== 1'b1) begin
            n_fail++;
            $display("FAIL unlock_z: got %b want 1", bus.z);
        end
        step(1'b0, 4'b1011);
        n_checks++;
        if ({bus.z, bus.valid, bus.data_out, bus.hamming_out} !== {1'b0, 1'b1, 4'b1011, 7'b1010101}) begin
            n_fail++;
            $display("FAIL load_1011: got %b want %b", {bus.z, bus.valid, bus.data_out, bus.hamming_out}, {1'b0, 1'b1, 4'b1011, 7'b1010101});
        end
    endtask

    task automatic test_wrong_code();
        logic [5:0] seq;
        logic [3:0] prior;
        seq   = 6'b101000;
        prior = m_data;
        for (int i = 5; i >= 0; i--) begin
            step(seq[i], 4'b1111);
            n_checks++;
            if (bus.z !== 1'b0 || bus.data_out !== prior) begin
                n_fail++;
                $display("FAIL wrong_code[%0d]: got z=%b data=%b want z=0 data=%b", i, bus.z, bus.data_out, prior);
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] seq;
        int         hits[$];
        seq = 7'b1101101;
        for (int i = 6; i >= 0; i--) begin
            step(seq[i], 4'b0001);
            if (bus.z === 1'b1) hits.push_back(6 - i);
            n_checks++;
            if ({bus.z, bus.valid, bus.data_out, bus.hamming_out} !== expected_bus()) begin
                n_fail++;
                $display("FAIL overlap_seq[%0d]: got %b want %b", i, {bus.z, bus.valid, bus.data_out, bus.hamming_out}, expected_bus());
            end
        end
        n_checks++;
        if (hits.size() != 2 || hits[1] - hits[0] != 3) begin
            n_fail++;
            $display("FAIL overlap_pulses: got %0d pulses want 2 spaced 3", hits.size());
        end
        step(1'b0, 4'b0001);
        n_checks++;
        if (bus.hamming_out !== 7'b0000111) begin
            n_fail++;
            $display("FAIL overlap_ham: got %b want 0000111", bus.hamming_out);
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] xs;
        xs = CODE;
        for (int n = 0; n < 16; n++) begin
            for (int i = CL - 1; i >= 0; i--)
                step(xs[i], 4'(n));
            step(1'b0, 4'(n));
            n_checks++;
            if (bus.data_out !== 4'(n) || bus.hamming_out !== ref_ham(4'(n))) begin
                n_fail++;
                $display("FAIL encode_%0d: got data=%b ham=%b want data=%b ham=%b", n, bus.data_out, bus.hamming_out, 4'(n), ref_ham(4'(n)));
            end
        end
        n_checks++;
        if (bus.hamming_out !== 7'b1111111) begin
            n_fail++;
            $display("FAIL encode_1111: got %b want 1111111", bus.hamming_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            n_checks++;
            if ({bus.z, bus.valid, bus.data_out, bus.hamming_out} !== expected_bus()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b want %b", c, {bus.z, bus.valid, bus.data_out, bus.hamming_out}, expected_bus());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] xs;
        xs = CODE;
        for (int i = CL - 1; i >= 0; i--)
            step(xs[i], 4'b0110);
        step(1'b0, 4'b0110);
        for (int i = CL - 1; i >= 0; i--)
            step(xs[i], 4'b1001);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.z, bus.valid, bus.data_out, bus.hamming_out} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want 0", {bus.z, bus.valid, bus.data_out, bus.hamming_out});
        end
        @(negedge clk);
        rst = 1'b1;
        step(xs[3], 4'b1001);
        step(xs[2], 4'b1001);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(xs[1], 4'b1001);
        step(xs[0], 4'b1001);
        n_checks++;
        if (bus.z !== 1'b0 || bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_partial: got z=%b valid=%b want 0 0", bus.z, bus.valid);
        end
    endtask

`ifdef UNLOCK_STICKY_EN
    task automatic test_sticky();
        for (int c = 0; c < 4; c++) begin
            step(1'($urandom_range(0, 1)), 4'b0101);
            n_checks++;
            if (bus.z !== 1'b1 || bus.data_out !== 4'b0101 || bus.hamming_out !== ref_ham(4'b0101)) begin
                n_fail++;
                $display("FAIL sticky[%0d]: got z=%b data=%b ham=%b", c, bus.z, bus.data_out, bus.hamming_out);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_unlock_load();
`ifdef UNLOCK_STICKY_EN
        test_sticky();
`else
        test_wrong_code();
        test_overlap();
        test_exhaustive();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
